change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Sequences the coin-return ejectors after a sale or cancel. Takes a change amount in cents and pays it out greedily
//  (dollar, quarter, dime, nickel), one timed solenoid pulse per coin, while tracking per-denomination inventory.
//  Reports any amount it could not pay. Sits between vending_machine (change/cancel result) and the ejector pins.
// PARAMETERS
//  PULSE_CYCLES  4   cycles each eject output is held high (>=1)
//  GAP_CYCLES    4   cycles all ejects are low between coins (>=1)
//  INV_INIT      20  coins per denomination after reset/restock (<=255)
//  AMT_W         10  width of amount/shortfall in cents (covers $5 bill)
// PORTS
//  clk           in   1      system clock, all state on rising edge
//  rstN          in   1      asynchronous, active-low reset
//  start         in   1      request payout of amount; sampled only in IDLE
//  amount        in   AMT_W  change to pay, cents
//  restock       in   1      reload all inventories to INV_INIT; honoured only in IDLE
//  busy          out  1      high from cycle after accepted start until DONE exits
//  done          out  1      one-cycle pulse: payout finished
//  shortfall     out  AMT_W  cents not paid by last payout; held until next accepted start
//  ejectDollar   out  1      ejector pulse, 100c
//  ejectQuarter  out  1      ejector pulse, 25c
//  ejectDime     out  1      ejector pulse, 10c
//  ejectNickel   out  1      ejector pulse, 5c
//  emptyMask     out  4      {dollar,quarter,dime,nickel} inventory==0 flags
// BEHAVIOUR
//  Reset (rstN=0, async): state IDLE; all ejects, busy, done=0; shortfall=0; remaining=0; inventories=INV_INIT.
//    Reset mid-payout drops any high eject immediately; the partially paid amount is lost, with no resume.
//  States: IDLE -> SELECT -> PULSE -> GAP -> SELECT ... -> DONE -> IDLE.
//  IDLE: start=1 at edge T: remaining<=amount, shortfall<=0, goto SELECT (busy=1 from T+1).
//    restock=1 with start=1 in the same cycle: restock applied first, start accepted.
//  SELECT (1 cycle): pick largest d in {100,25,10,5} with d<=remaining and inv[d]>0.
//    Found: remaining-=d, inv[d]-=1, goto PULSE. None: shortfall<=remaining, goto DONE.
//  PULSE: exactly one eject high for PULSE_CYCLES, then goto GAP.
//  GAP: all ejects low for GAP_CYCLES, then goto SELECT.
//  DONE: done=1, busy=1 for one cycle, then goto IDLE.
//  Latency: first eject high at cycle T+2. Per coin: 1+PULSE_CYCLES+GAP_CYCLES cycles.
//    amount=0: done at T+2.
//  Arithmetic: remaining never underflows (d<=remaining checked). Amounts not a multiple of 5 leave remainder
//    1..4 in shortfall. Inventory never decrements below 0.
//  start while busy: ignored, no queueing. restock while busy: ignored. amount: sampled only at accept.
//  Ejects are registered outputs, never two high at once.
//  emptyMask is combinational from the inventory registers.
// STRUCTURE
//  vm_pkg: coin value constants (5/10/25/100), coin index enum (NICKEL..DOLLAR), state encoding, AMT_W default.
//  Sub-module coin_timer: loadable down-counter that pulses expired; shared by PULSE and GAP.
//  Top level holds FSM, remaining register, four 8-bit inventory counters and greedy select logic.
// TESTING
//  1 reset, start amount=140 -> dollar, quarter, dime, nickel ejects in order, each 4 cycles high / 4 low;
//    done, shortfall=0; each inventory=19.
//  2 amount=0 -> no ejects, done high at T+2, busy high at T+1..T+2.
//  3 INV_INIT=1: pay 10, then pay 10 -> second payout: one nickel, shortfall=5, emptyMask=4'b0011.
//  4 amount=53 -> two quarters, shortfall=3.
//  5 start asserted mid-payout (amount=25) -> ignored. restock in IDLE after test 3 -> emptyMask=0.
//  6 rstN=0 during a PULSE -> eject low same cycle, busy=0, inventories=INV_INIT, shortfall=0.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared constants and types for the coin-return dispenser: coin values,
// coin index encoding and FSM state encoding.
package change_dispenser_pkg;

    localparam int unsigned AMT_W_DEF     = 10;
    localparam int unsigned CENTS_NICKEL  = 5;
    localparam int unsigned CENTS_DIME    = 10;
    localparam int unsigned CENTS_QUARTER = 25;
    localparam int unsigned CENTS_DOLLAR  = 100;

    // Index order doubles as the bit position in the eject vector and emptyMask.
    typedef enum logic [1:0] {
        NICKEL  = 2'd0,
        DIME    = 2'd1,
        QUARTER = 2'd2,
        DOLLAR  = 2'd3
    } coin_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_PULSE  = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    function automatic int unsigned coin_cents(input coin_e c);
        case (c)
            NICKEL:  coin_cents = CENTS_NICKEL;
            DIME:    coin_cents = CENTS_DIME;
            QUARTER: coin_cents = CENTS_QUARTER;
            default: coin_cents = CENTS_DOLLAR;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_coin_timer.sv
// Loadable down-counter timing both the solenoid pulse and the inter-coin gap.
// o_expired is high whenever the count has reached zero.
module coin_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy change payout: one timed eject pulse per coin, largest available coin
// first, with per-denomination inventory and reporting of any unpaid remainder.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int INV_INIT     = 20,
    parameter int AMT_W        = AMT_W_DEF
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             restock,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] shortfall,
    output logic             ejectDollar,
    output logic             ejectQuarter,
    output logic             ejectDime,
    output logic             ejectNickel,
    output logic [3:0]       emptyMask
);

    localparam logic [AMT_W-1:0] VAL_NICKEL  = AMT_W'(coin_cents(NICKEL));
    localparam logic [AMT_W-1:0] VAL_DIME    = AMT_W'(coin_cents(DIME));
    localparam logic [AMT_W-1:0] VAL_QUARTER = AMT_W'(coin_cents(QUARTER));
    localparam logic [AMT_W-1:0] VAL_DOLLAR  = AMT_W'(coin_cents(DOLLAR));
    localparam logic [7:0]       INV_FULL    = 8'(INV_INIT);
    localparam logic [7:0]       PULSE_LOAD  = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0]       GAP_LOAD    = 8'(GAP_CYCLES - 1);

    state_e           r_state;
    logic [AMT_W-1:0] r_remaining;
    logic [AMT_W-1:0] r_shortfall;
    logic [7:0]       r_inv [0:3];
    logic [3:0]       r_eject;
    logic             r_busy;
    logic             r_done;

    logic             w_found;
    coin_e            w_coin;
    logic [AMT_W-1:0] w_value;
    logic             w_expired;
    logic             w_tmr_load;
    logic [7:0]       w_tmr_value;

    // Largest coin that both fits in the remainder and is still in stock.
    always_comb begin
        w_found = 1'b0;
        w_coin  = NICKEL;
        w_value = '0;
        if (r_inv[DOLLAR] != 8'd0 && r_remaining >= VAL_DOLLAR) begin
            w_found = 1'b1;
            w_coin  = DOLLAR;
            w_value = VAL_DOLLAR;
        end else if (r_inv[QUARTER] != 8'd0 && r_remaining >= VAL_QUARTER) begin
            w_found = 1'b1;
            w_coin  = QUARTER;
            w_value = VAL_QUARTER;
        end else if (r_inv[DIME] != 8'd0 && r_remaining >= VAL_DIME) begin
            w_found = 1'b1;
            w_coin  = DIME;
            w_value = VAL_DIME;
        end else if (r_inv[NICKEL] != 8'd0 && r_remaining >= VAL_NICKEL) begin
            w_found = 1'b1;
            w_coin  = NICKEL;
            w_value = VAL_NICKEL;
        end
    end

    assign w_tmr_load  = ((r_state == S_SELECT) && w_found) ||
                         ((r_state == S_PULSE) && w_expired);
    assign w_tmr_value = (r_state == S_SELECT) ? PULSE_LOAD : GAP_LOAD;

    coin_timer #(.CNT_W(8)) u_timer (
        .clk       (clk),
        .rstN      (rstN),
        .i_load    (w_tmr_load),
        .i_value   (w_tmr_value),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_shortfall <= '0;
            r_eject     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            for (int i = 0; i < 4; i++) r_inv[i] <= INV_FULL;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (restock) begin
                        for (int i = 0; i < 4; i++) r_inv[i] <= INV_FULL;
                    end
                    if (start) begin
                        r_remaining <= amount;
                        r_shortfall <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (w_found) begin
                        r_remaining   <= r_remaining - w_value;
                        r_inv[w_coin] <= r_inv[w_coin] - 8'd1;
                        r_eject       <= 4'b0001 << w_coin;
                        r_state       <= S_PULSE;
                    end else begin
                        r_shortfall <= r_remaining;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_PULSE: begin
                    if (w_expired) begin
                        r_eject <= '0;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (w_expired) r_state <= S_SELECT;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign shortfall    = r_shortfall;
    assign ejectDollar  = r_eject[DOLLAR];
    assign ejectQuarter = r_eject[QUARTER];
    assign ejectDime    = r_eject[DIME];
    assign ejectNickel  = r_eject[NICKEL];
    assign emptyMask    = {r_inv[DOLLAR] == 8'd0, r_inv[QUARTER] == 8'd0,
                           r_inv[DIME] == 8'd0, r_inv[NICKEL] == 8'd0};

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a full-stock instance and a one-coin
// stock instance, selected by sel, with hand-computed expected values.
module tb_change_dispenser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstN;
    logic       start;
    logic       restock;
    logic       sel;
    logic [9:0] amount;

    logic       start0, start1, restock0, restock1;
    logic       busy0, done0, ed0, eq0, edi0, en0;
    logic       busy1, done1, ed1, eq1, edi1, en1;
    logic [9:0] sf0, sf1;
    logic [3:0] em0, em1;

    logic       w_busy, w_done;
    logic [9:0] w_sf;
    logic [3:0] w_ej, w_em;

    int n_cmp  = 0;
    int n_fail = 0;

    assign start0   = start & ~sel;
    assign start1   = start & sel;
    assign restock0 = restock & ~sel;
    assign restock1 = restock & sel;
    assign w_busy   = sel ? busy1 : busy0;
    assign w_done   = sel ? done1 : done0;
    assign w_sf     = sel ? sf1 : sf0;
    assign w_em     = sel ? em1 : em0;
    assign w_ej     = sel ? {ed1, eq1, edi1, en1} : {ed0, eq0, edi0, en0};

    change_dispenser #(.PULSE_CYCLES(4), .GAP_CYCLES(4), .INV_INIT(20), .AMT_W(10)) dut (
        .clk(clk), .rstN(rstN), .start(start0), .amount(amount), .restock(restock0),
        .busy(busy0), .done(done0), .shortfall(sf0),
        .ejectDollar(ed0), .ejectQuarter(eq0), .ejectDime(edi0), .ejectNickel(en0),
        .emptyMask(em0)
    );

    change_dispenser #(.PULSE_CYCLES(4), .GAP_CYCLES(4), .INV_INIT(1), .AMT_W(10)) dut1 (
        .clk(clk), .rstN(rstN), .start(start1), .amount(amount), .restock(restock1),
        .busy(busy1), .done(done1), .shortfall(sf1),
        .ejectDollar(ed1), .ejectQuarter(eq1), .ejectDime(edi1), .ejectNickel(en1),
        .emptyMask(em1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Accept edge T happens inside; returns in cycle T+1 (SELECT).
    task automatic pay(input logic [9:0] a);
        amount = a;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("busy_t1", 32'(w_busy), 32'd1);
        check("done_t1", 32'(w_done), 32'd0);
    endtask

    // From a SELECT cycle: 4 cycles of mask high, 4 low, ends in the next SELECT.
    task automatic coin(input logic [3:0] m, input string tag);
        for (int i = 0; i < 4; i++) begin
            tick();
            check({tag, "_pulse"}, 32'(w_ej), 32'(m));
            check({tag, "_busy"}, 32'(w_busy), 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check({tag, "_gap"}, 32'(w_ej), 32'd0);
        end
        tick();
        check({tag, "_select"}, 32'(w_ej), 32'd0);
    endtask

    task automatic finish_pay(input logic [9:0] sf);
        tick();
        check("done_pulse", 32'(w_done), 32'd1);
        check("done_busy", 32'(w_busy), 32'd1);
        check("shortfall", 32'(w_sf), 32'(sf));
        tick();
        check("done_clear", 32'(w_done), 32'd0);
        check("busy_clear", 32'(w_busy), 32'd0);
        check("shortfall_held", 32'(w_sf), 32'(sf));
    endtask

    initial begin
        rstN    = 1'b0;
        start   = 1'b0;
        restock = 1'b0;
        sel     = 1'b0;
        amount  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_eject", 32'({ed0, eq0, edi0, en0}), 32'd0);
        check("rst_shortfall", 32'(sf0), 32'd0);
        check("rst_empty0", 32'(em0), 32'd0);
        check("rst_empty1", 32'(em1), 32'd0);
        check("rst_inv_dollar", 32'(dut.r_inv[3]), 32'd20);
        rstN = 1'b1;
        tick();

        // 140c: one of each coin, largest first
        pay(10'd140);
        coin(4'b1000, "t1_dollar");
        coin(4'b0100, "t1_quarter");
        coin(4'b0010, "t1_dime");
        coin(4'b0001, "t1_nickel");
        finish_pay(10'd0);
        check("t1_inv_nickel", 32'(dut.r_inv[0]), 32'd19);
        check("t1_inv_dime", 32'(dut.r_inv[1]), 32'd19);
        check("t1_inv_quarter", 32'(dut.r_inv[2]), 32'd19);
        check("t1_inv_dollar", 32'(dut.r_inv[3]), 32'd19);

        // zero amount: done at T+2
        pay(10'd0);
        tick();
        check("t2_done", 32'(w_done), 32'd1);
        check("t2_busy", 32'(w_busy), 32'd1);
        check("t2_eject", 32'(w_ej), 32'd0);
        tick();
        check("t2_done_clear", 32'(w_done), 32'd0);
        check("t2_busy_clear", 32'(w_busy), 32'd0);

        // 53c: two quarters, 3c unpayable
        pay(10'd53);
        coin(4'b0100, "t4_q1");
        coin(4'b0100, "t4_q2");
        finish_pay(10'd3);
        check("t4_inv_quarter", 32'(dut.r_inv[2]), 32'd17);
        check("t4_inv_dime", 32'(dut.r_inv[1]), 32'd19);

        // start and restock while busy are both ignored
        pay(10'd25);
        start   = 1'b1;
        amount  = 10'd100;
        restock = 1'b1;
        coin(4'b0100, "t5_quarter");
        start   = 1'b0;
        restock = 1'b0;
        finish_pay(10'd0);
        check("t5_inv_quarter", 32'(dut.r_inv[2]), 32'd16);
        check("t5_inv_dollar", 32'(dut.r_inv[3]), 32'd19);

        // one-coin stock: second 10c payout falls back to a nickel
        sel = 1'b1;
        pay(10'd10);
        coin(4'b0010, "t3_dime");
        finish_pay(10'd0);
        pay(10'd10);
        coin(4'b0001, "t3_nickel");
        finish_pay(10'd5);
        check("t3_empty", 32'(w_em), 32'b0011);
        restock = 1'b1;
        tick();
        restock = 1'b0;
        check("t3_restock_empty", 32'(w_em), 32'd0);
        check("t3_restock_busy", 32'(w_busy), 32'd0);

        // reset in the middle of a dollar pulse
        sel = 1'b0;
        pay(10'd140);
        tick();
        tick();
        check("t6_pre_eject", 32'(w_ej), 32'b1000);
        rstN = 1'b0;
        #1;
        check("t6_eject", 32'(w_ej), 32'd0);
        check("t6_busy", 32'(w_busy), 32'd0);
        check("t6_shortfall", 32'(w_sf), 32'd0);
        check("t6_inv_dollar", 32'(dut.r_inv[3]), 32'd20);
        check("t6_inv_quarter", 32'(dut.r_inv[2]), 32'd20);
        tick();
        rstN = 1'b1;
        repeat (3) tick();
        check("t6_no_resume_eject", 32'(w_ej), 32'd0);
        check("t6_no_resume_busy", 32'(w_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
